// File: rtl/biu88_if.sv
// Bus bundle for the 8088 bus interface unit: memory port, prefetch queue
// head and core data-access handshake. The BIU is the slave side; the
// execution unit plus memory (or a testbench) form the master side.
interface biu88_if #(
  parameter int ADDR_W = 20
);
  // memory port
  logic              ready;
  logic [ADDR_W-1:0] mem_address;
  logic [7:0]        mem_rdata;
  logic [7:0]        mem_wdata;
  logic              mem_wreq;
  // fetch redirect
  logic              flush;
  logic [15:0]       flush_cs;
  logic [15:0]       flush_ip;
  // prefetch queue head
  logic              q_valid;
  logic [7:0]        q_data;
  logic [15:0]       q_ip;
  logic              q_pop;
  // core data access
  logic              d_req;
  logic              d_we;
  logic              d_word;
  logic [15:0]       d_seg;
  logic [15:0]       d_off;
  logic [15:0]       d_wdata;
  logic              d_busy;
  logic              d_done;
  logic [15:0]       d_rdata;

  modport slave (
    input  ready, mem_rdata, flush, flush_cs, flush_ip, q_pop,
           d_req, d_we, d_word, d_seg, d_off, d_wdata,
    output mem_address, mem_wdata, mem_wreq, q_valid, q_data, q_ip,
           d_busy, d_done, d_rdata
  );

  modport master (
    output ready, mem_rdata, flush, flush_cs, flush_ip, q_pop,
           d_req, d_we, d_word, d_seg, d_off, d_wdata,
    input  mem_address, mem_wdata, mem_wreq, q_valid, q_data, q_ip,
           d_busy, d_done, d_rdata
  );
endinterface

// File: rtl/biu88.sv
// Bus interface unit for the 8088 core family. Owns the single byte-wide
// memory port, keeps a QDEPTH-byte prefetch queue filled from CS:IP and
// slots core data accesses (byte/word, read/write) in ahead of prefetch,
// splitting words into a low-byte and a high-byte cycle.
module biu88 #(
  parameter int QDEPTH = 4,
  parameter int ADDR_W = 20
) (
  input  logic   clock,
  input  logic   reset,
  biu88_if.slave bus
);

  typedef enum logic [1:0] {FETCH, DLO, DHI} state_t;

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam int SW = (ADDR_W > 20) ? ADDR_W : 20;

  // Segment:offset to physical byte address, truncated to the bus width.
  function automatic logic [ADDR_W-1:0] phys(input logic [15:0] seg, input logic [15:0] off);
    logic [SW:0] sum;
    sum = (SW+1)'({seg, 4'h0}) + (SW+1)'(off);
    return sum[ADDR_W-1:0];
  endfunction

  state_t            state_reg, state_next;
  logic [15:0]       cs_reg, ip_reg;
  logic [PW-1:0]     head_reg, tail_reg;
  logic [CW-1:0]     count_reg;
  logic [7:0]        q_mem [QDEPTH];
  logic              we_reg, word_reg;
  logic [15:0]       seg_reg, off_reg, wdata_reg;
  logic              done_reg;
  logic [15:0]       rdata_reg;

  logic              push, pop, accept;
  logic [ADDR_W-1:0] addr_out;
  logic [7:0]        wdata_out;
  logic              wreq_out;

  // Next state and the current transfer's address/strobe; data cycles win over prefetch.
  always_comb begin
    state_next = state_reg;
    push       = 1'b0;
    accept     = 1'b0;
    addr_out   = phys(cs_reg, ip_reg);
    wdata_out  = 8'h00;
    wreq_out   = 1'b0;
    case (state_reg)
      FETCH: begin
        // a flush in this cycle throws the fetched byte away, so don't push it
        push   = (count_reg < CW'(QDEPTH)) && !bus.flush;
        accept = bus.d_req;
        if (bus.d_req) state_next = DLO;
      end
      DLO: begin
        addr_out   = phys(seg_reg, off_reg);
        wdata_out  = we_reg ? wdata_reg[7:0] : 8'h00;
        wreq_out   = we_reg;
        state_next = word_reg ? DHI : FETCH;
      end
      DHI: begin
        // high byte stays inside the segment: offset wraps at 64K
        addr_out   = phys(seg_reg, off_reg + 16'd1);
        wdata_out  = we_reg ? wdata_reg[15:8] : 8'h00;
        wreq_out   = we_reg;
        state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase
  end

  // Pops are honoured in any state; a flush overrides both push and pop.
  assign pop = bus.q_pop && (count_reg != '0) && !bus.flush;

  // State register; ready=0 freezes everything.
  always_ff @(posedge clock) begin
    if (reset)          state_reg <= FETCH;
    else if (bus.ready) state_reg <= state_next;
  end

  // Prefetch pointers, occupancy and the CS:IP fetch position.
  always_ff @(posedge clock) begin
    if (reset) begin
      cs_reg    <= 16'hF000;
      ip_reg    <= 16'h0000;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (bus.ready) begin
      if (bus.flush) begin
        cs_reg    <= bus.flush_cs;
        ip_reg    <= bus.flush_ip;
        head_reg  <= '0;
        tail_reg  <= '0;
        count_reg <= '0;
      end else begin
        if (push) begin
          tail_reg <= tail_reg + 1'b1;
          ip_reg   <= ip_reg + 16'd1;
        end
        if (pop) head_reg <= head_reg + 1'b1;
        case ({push, pop})
          2'b10:   count_reg <= count_reg + CW'(1);
          2'b01:   count_reg <= count_reg - CW'(1);
          default: count_reg <= count_reg;
        endcase
      end
    end
  end

  // Queue storage; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clock) begin
    if (!reset && bus.ready && push) q_mem[tail_reg] <= bus.mem_rdata;
  end

  // Data access: latch the request, collect read bytes, pulse done after the last byte.
  always_ff @(posedge clock) begin
    if (reset) begin
      we_reg    <= 1'b0;
      word_reg  <= 1'b0;
      seg_reg   <= 16'h0000;
      off_reg   <= 16'h0000;
      wdata_reg <= 16'h0000;
      done_reg  <= 1'b0;
      rdata_reg <= 16'h0000;
    end else if (bus.ready) begin
      if (accept) begin
        we_reg    <= bus.d_we;
        word_reg  <= bus.d_word;
        seg_reg   <= bus.d_seg;
        off_reg   <= bus.d_off;
        wdata_reg <= bus.d_wdata;
      end
      if (state_reg == DLO && !we_reg) rdata_reg <= {8'h00, bus.mem_rdata};
      if (state_reg == DHI && !we_reg) rdata_reg[15:8] <= bus.mem_rdata;
      done_reg <= (state_reg == DHI) || (state_reg == DLO && !word_reg);
    end
  end

  assign bus.mem_address = addr_out;
  assign bus.mem_wdata   = wdata_out;
  assign bus.mem_wreq    = wreq_out;
  assign bus.q_valid     = (count_reg != '0);
  assign bus.q_data      = q_mem[head_reg];
  assign bus.q_ip        = ip_reg - 16'(count_reg);
  assign bus.d_busy      = (state_reg != FETCH);
  assign bus.d_done      = done_reg;
  assign bus.d_rdata     = rdata_reg;

endmodule

// File: tb/tb_biu88.sv
// Bench for biu88: a transaction-level model (queue of pending byte
// transfers, queue of prefetched bytes) is checked every cycle, and
// directed scenarios pin literal values at key cycles.
module tb_biu88;
  localparam int QD = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  biu88_if #(.ADDR_W(20)) bus ();
  biu88 #(.QDEPTH(QD), .ADDR_W(20)) dut (.clock(clk), .reset(rst), .bus(bus.slave));

  // memory: combinational read, write at the edge of a strobed, ready cycle
  logic [7:0] mem [0:(1<<20)-1];
  assign bus.mem_rdata = mem[bus.mem_address];
  always @(posedge clk) begin
    if (bus.ready && bus.mem_wreq) mem[bus.mem_address] = bus.mem_wdata;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {logic [19:0] a; bit we; logic [7:0] wd; bit hi;} xf_t;
  typedef struct {logic [7:0] d; logic [15:0] ip;} qe_t;
  xf_t         xq[$];
  qe_t         mq[$];
  logic [15:0] m_cs, m_ip, m_rd;
  bit          m_done;
  bit          live = 0;

  function automatic logic [19:0] pa(input logic [15:0] s, input logic [15:0] o);
    int v;
    v = (int'(s) * 16 + int'(o)) % (1 << 20);
    return v[19:0];
  endfunction

  always @(posedge clk) begin
    bit  busy, do_pop, do_fetch;
    xf_t t;
    qe_t e;
    if (rst) begin
      xq.delete(); mq.delete();
      m_cs = 16'hF000; m_ip = 16'h0000; m_rd = 16'h0000; m_done = 0; live = 1;
    end else if (live && bus.ready) begin
      busy     = (xq.size() != 0);
      m_done   = (xq.size() == 1);
      do_pop   = !bus.flush && bus.q_pop && mq.size() != 0;
      do_fetch = !busy && !bus.flush && mq.size() < QD;
      if (busy) begin
        t = xq.pop_front();
        if (!t.we) begin
          if (t.hi) m_rd[15:8] = mem[t.a];
          else      m_rd = {8'h00, mem[t.a]};
        end
      end else if (bus.d_req) begin
        t.we = bus.d_we; t.hi = 0;
        t.a = pa(bus.d_seg, bus.d_off); t.wd = bus.d_wdata[7:0];
        xq.push_back(t);
        if (bus.d_word) begin
          t.hi = 1; t.a = pa(bus.d_seg, bus.d_off + 16'd1); t.wd = bus.d_wdata[15:8];
          xq.push_back(t);
        end
      end
      if (do_pop) void'(mq.pop_front());
      if (do_fetch) begin
        e.d = mem[pa(m_cs, m_ip)]; e.ip = m_ip;
        mq.push_back(e);
        m_ip = m_ip + 16'd1;
      end
      if (bus.flush) begin
        mq.delete(); m_cs = bus.flush_cs; m_ip = bus.flush_ip;
      end
    end
  end

  // compare DUT to model mid-cycle
  always @(negedge clk) begin
    logic [19:0] ea;
    bit          xb, xw;
    if (live) begin
      xb = (xq.size() != 0);
      xw = xb && xq[0].we;
      ea = xb ? xq[0].a : pa(m_cs, m_ip);
      chk("m_addr", 32'(bus.mem_address), 32'(ea));
      chk("m_wreq", 32'(bus.mem_wreq), 32'(xw));
      if (xw) chk("m_wdata", 32'(bus.mem_wdata), 32'(xq[0].wd));
      chk("m_busy", 32'(bus.d_busy), 32'(xb));
      chk("m_done", 32'(bus.d_done), 32'(m_done));
      if (m_done) chk("m_rdata", 32'(bus.d_rdata), 32'(m_rd));
      chk("m_qvalid", 32'(bus.q_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("m_qdata", 32'(bus.q_data), 32'(mq[0].d));
        chk("m_qip", 32'(bus.q_ip), 32'(mq[0].ip));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  logic [7:0] exp_b [4];

  initial begin
    rst = 1'b1;
    bus.ready = 1'b1; bus.flush = 1'b0; bus.flush_cs = '0; bus.flush_ip = '0;
    bus.q_pop = 1'b0; bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_word = 1'b0;
    bus.d_seg = '0; bus.d_off = '0; bus.d_wdata = '0;
    for (int i = 0; i < (1 << 20); i++) mem[i] = 8'(i * 7 + 3);
    mem[20'hF0000] = 8'h90; mem[20'hF0001] = 8'hB8; mem[20'hF0002] = 8'h34;
    mem[20'hF0003] = 8'h12; mem[20'hF0004] = 8'hCD;
    mem[20'h2233F] = 8'hCD; mem[20'h12340] = 8'hAB;
    mem[20'h07C00] = 8'hEA;
    mem[20'h00100] = 8'h11; mem[20'h00101] = 8'h22;
    exp_b = '{8'h90, 8'hB8, 8'h34, 8'h12};

    // reset state
    tick(2);
    chk("rst_qvalid", 32'(bus.q_valid), 32'h0);
    chk("rst_busy", 32'(bus.d_busy), 32'h0);
    chk("rst_done", 32'(bus.d_done), 32'h0);
    chk("rst_rdata", 32'(bus.d_rdata), 32'h0000);
    chk("rst_wreq", 32'(bus.mem_wreq), 32'h0);
    chk("rst_wdata", 32'(bus.mem_wdata), 32'h00);
    chk("rst_addr", 32'(bus.mem_address), 32'hF0000);
    rst = 1'b0;

    // prefetch fills queue then stalls at F0004
    tick(6);
    chk("t1_addr_stall", 32'(bus.mem_address), 32'hF0004);
    chk("t1_qvalid", 32'(bus.q_valid), 32'h1);
    for (int k = 0; k < 4; k++) begin
      chk("t1_qdata", 32'(bus.q_data), 32'(exp_b[k]));
      chk("t1_qip", 32'(bus.q_ip), 32'(k));
      bus.q_pop = 1'b1;
      tick(1);
    end
    bus.q_pop = 1'b0;
    tick(3);

    // word read across offset wrap
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_word = 1'b1;
    bus.d_seg = 16'h1234; bus.d_off = 16'hFFFF;
    tick(1);
    bus.d_req = 1'b0;
    chk("t2_busy", 32'(bus.d_busy), 32'h1);
    chk("t2_addr_lo", 32'(bus.mem_address), 32'h2233F);
    tick(1);
    chk("t2_addr_hi", 32'(bus.mem_address), 32'h12340);
    tick(1);
    chk("t2_done", 32'(bus.d_done), 32'h1);
    chk("t2_rdata", 32'(bus.d_rdata), 32'hABCD);
    chk("t2_busy_end", 32'(bus.d_busy), 32'h0);
    tick(1);
    chk("t2_done_pulse", 32'(bus.d_done), 32'h0);

    // word write; request held into the busy cycle must be ignored
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_word = 1'b1;
    bus.d_seg = 16'h0000; bus.d_off = 16'h0010; bus.d_wdata = 16'hBEEF;
    tick(1);
    chk("t3_addr_lo", 32'(bus.mem_address), 32'h00010);
    chk("t3_wdata_lo", 32'(bus.mem_wdata), 32'hEF);
    chk("t3_wreq_lo", 32'(bus.mem_wreq), 32'h1);
    tick(1);
    bus.d_req = 1'b0;
    chk("t3_addr_hi", 32'(bus.mem_address), 32'h00011);
    chk("t3_wdata_hi", 32'(bus.mem_wdata), 32'hBE);
    tick(1);
    chk("t3_done", 32'(bus.d_done), 32'h1);
    chk("t3_wreq_end", 32'(bus.mem_wreq), 32'h0);
    chk("t3_busy_end", 32'(bus.d_busy), 32'h0);
    chk("t3_mem_lo", 32'(mem[20'h00010]), 32'hEF);
    chk("t3_mem_hi", 32'(mem[20'h00011]), 32'hBE);

    // flush with simultaneous pop on a full queue
    tick(6);
    chk("t4_full_valid", 32'(bus.q_valid), 32'h1);
    bus.flush = 1'b1; bus.flush_cs = 16'h0000; bus.flush_ip = 16'h7C00; bus.q_pop = 1'b1;
    tick(1);
    bus.flush = 1'b0; bus.q_pop = 1'b0;
    chk("t4_qvalid0", 32'(bus.q_valid), 32'h0);
    chk("t4_addr", 32'(bus.mem_address), 32'h07C00);
    tick(1);
    chk("t4_qvalid1", 32'(bus.q_valid), 32'h1);
    chk("t4_qip", 32'(bus.q_ip), 32'h7C00);
    chk("t4_qdata", 32'(bus.q_data), 32'hEA);

    // ready low for three cycles between the two halves of a word read
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_word = 1'b1;
    bus.d_seg = 16'h0000; bus.d_off = 16'h0100;
    tick(1);
    bus.d_req = 1'b0;
    chk("t5_addr_lo", 32'(bus.mem_address), 32'h00100);
    tick(1);
    bus.ready = 1'b0;
    chk("t5_addr_hi", 32'(bus.mem_address), 32'h00101);
    for (int k = 0; k < 3; k++) begin
      tick(1);
      chk("t5_hold_addr", 32'(bus.mem_address), 32'h00101);
      chk("t5_hold_done", 32'(bus.d_done), 32'h0);
    end
    bus.ready = 1'b1;
    tick(1);
    chk("t5_done", 32'(bus.d_done), 32'h1);
    chk("t5_rdata", 32'(bus.d_rdata), 32'h2211);
    // done pulse stretched by a stall
    bus.ready = 1'b0;
    tick(2);
    chk("t5_done_held", 32'(bus.d_done), 32'h1);
    bus.ready = 1'b1;
    tick(1);
    chk("t5_done_clear", 32'(bus.d_done), 32'h0);

    // reset during the high-byte cycle of a word write
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_word = 1'b1;
    bus.d_seg = 16'h0000; bus.d_off = 16'h0200; bus.d_wdata = 16'h1357;
    tick(1);
    bus.d_req = 1'b0;
    chk("t6_wdata_lo", 32'(bus.mem_wdata), 32'h57);
    tick(1);
    chk("t6_addr_hi", 32'(bus.mem_address), 32'h00201);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("t6_wreq", 32'(bus.mem_wreq), 32'h0);
    chk("t6_busy", 32'(bus.d_busy), 32'h0);
    chk("t6_addr", 32'(bus.mem_address), 32'hF0000);
    chk("t6_qvalid", 32'(bus.q_valid), 32'h0);
    tick(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
